// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and its FIFO.
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN; 2'b11 also means none)
//   - transmitter FSM state type
//   - frame_cfg_t: per-frame configuration captured when a word is popped
//   - helpers for parity enable / parity bit computation
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Width of the divisor field inside frame_cfg_t. The top level zero-extends
    // its DIV_W-bit divisor into this field, so DIV_W may be at most 32.
    localparam int CFG_DIV_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] baud_div;
        logic [1:0]           parity_type;
        logic                 stop_two;
    } frame_cfg_t;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

    // Data is zero-padded to 9 bits (the widest legal word); padding zeros do
    // not change the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] ptype);
        return (ptype == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO feeding the UART transmitter.
//   clock    in   system clock
//   reset    in   asynchronous active-high reset (flushes the FIFO)
//   wr_en    in   write request; ignored while full
//   wr_data  in   word to write
//   rd_en    in   read (pop) request; ignored while empty
//   rd_data  out  word at the head of the FIFO (valid whenever !empty)
//   count    out  number of stored words
//   empty    out  no words stored
//   full     out  FIFO_DEPTH words stored
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. All status outputs are functions of the pointer
// registers only, so they change on the edge after a push or pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            empty,
    output logic                            full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A write is refused while full even if a read happens on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // First-word fall-through: the head word must be present on the same edge
    // that pops it, because the transmitter loads its shift register there.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with ready/valid input FIFO.
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   tx_data      in   word to queue (DATA_W bits)
//   tx_valid     in   tx_data valid
//   tx_ready     out  FIFO can accept a word (!fifo_full)
//   baud_div     in   clocks per bit minus 1 (latched per frame)
//   parity_type  in   00 none, 01 odd, 10 even, 11 none (latched per frame)
//   stop_two     in   0 one stop bit, 1 two stop bits (latched per frame)
//   data_tx      out  serial line, idles high, registered
//   active_flag  out  high while a frame is on the line
//   done_flag    out  one-cycle pulse after each frame's last stop bit
//   fifo_count   out  words queued
//   fifo_empty   out  FIFO empty
//   fifo_full    out  FIFO full
// Frames go out back-to-back: when the last stop bit ends and a word is
// waiting, the next START begins on the same edge as the done pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  parity_type,
    input  logic                        stop_two,
    output logic                        data_tx,
    output logic                        active_flag,
    output logic                        done_flag,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_empty,
    output logic                        fifo_full
);

    localparam int IDX_W = $clog2(DATA_W);

    tx_state_t          state_reg;
    frame_cfg_t         cfg_reg;
    logic [DIV_W-1:0]   baud_cnt_reg;
    logic [IDX_W-1:0]   bit_idx_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic               parity_reg;
    logic               stop_idx_reg;
    logic               data_tx_reg;
    logic               active_reg;
    logic               done_reg;

    logic [DATA_W-1:0]  fifo_rd_data;
    logic               bit_end;
    logic               stop_done;
    logic               fifo_pop;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign tx_ready = !fifo_full;

    // Last clock of the current bit, measured against the latched divisor.
    assign bit_end   = (CFG_DIV_W'(baud_cnt_reg) == cfg_reg.baud_div);
    assign stop_done = (state_reg == STOP) && bit_end &&
                       (!cfg_reg.stop_two || stop_idx_reg);
    assign fifo_pop  = !fifo_empty && ((state_reg == IDLE) || stop_done);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cfg_reg      <= '0;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            stop_idx_reg <= 1'b0;
            data_tx_reg  <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (fifo_pop) begin
                // New frame: capture word and configuration, drive START.
                state_reg            <= START;
                cfg_reg.baud_div     <= CFG_DIV_W'(baud_div);
                cfg_reg.parity_type  <= parity_type;
                cfg_reg.stop_two     <= stop_two;
                shift_reg            <= fifo_rd_data;
                parity_reg           <= parity_bit(9'(fifo_rd_data), parity_type);
                baud_cnt_reg         <= '0;
                data_tx_reg          <= 1'b0;
                active_reg           <= 1'b1;
                if (state_reg == STOP) begin
                    done_reg <= 1'b1;
                end
            end else begin
                if (state_reg != IDLE) begin
                    baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;
                end
                case (state_reg)
                    START: begin
                        if (bit_end) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                            data_tx_reg <= shift_reg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx_reg == IDX_W'(DATA_W - 1)) begin
                                if (parity_enabled(cfg_reg.parity_type)) begin
                                    state_reg   <= PARITY;
                                    data_tx_reg <= parity_reg;
                                end else begin
                                    state_reg    <= STOP;
                                    stop_idx_reg <= 1'b0;
                                    data_tx_reg  <= 1'b1;
                                end
                            end else begin
                                // shift_reg[0] always holds the bit on the line.
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                                shift_reg   <= shift_reg >> 1;
                                data_tx_reg <= shift_reg[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state_reg    <= STOP;
                            stop_idx_reg <= 1'b0;
                            data_tx_reg  <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (!stop_done) begin
                                stop_idx_reg <= 1'b1;
                            end else begin
                                state_reg  <= IDLE;
                                active_reg <= 1'b0;
                                done_reg   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        data_tx_reg <= 1'b1;
                        active_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_tx     = data_tx_reg;
    assign active_flag = active_reg;
    assign done_flag   = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Accepted words go into a scoreboard queue; a
// negedge monitor derives each frame's expected start edge, bit sequence and
// end from the frame rules and compares the serial line, flags and FIFO
// status every cycle.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;

    logic                        clock;
    logic                        reset;
    logic [DATA_W-1:0]           tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [DIV_W-1:0]            baud_div;
    logic [1:0]                  parity_type;
    logic                        stop_two;
    logic                        data_tx;
    logic                        active_flag;
    logic                        done_flag;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_empty;
    logic                        fifo_full;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .baud_div    (baud_div),
        .parity_type (parity_type),
        .stop_two    (stop_two),
        .data_tx     (data_tx),
        .active_flag (active_flag),
        .done_flag   (done_flag),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                edge_no;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        done_q[$];
    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc = 0;
    bit        accepted_now = 0;
    int        n_accepted = 0;

    // monitor state
    bit        mon_active = 0;
    bit        exp_bits[13];
    int        n_bits, bit_time, frame_len, frame_start, pos, start_at;
    int        prev_end = 0;
    int        done_cyc = -1;
    int        cfg_baud_prev = 0;
    logic [1:0] cfg_par_prev = 2'b00;
    logic      cfg_stop_prev = 1'b0;
    logic      active_prev = 1'b0;
    int        last_rise = 0;
    sb_entry_t ent;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Edge counter and push model: a word is accepted when valid and the
    // model FIFO (scoreboard) holds fewer than FIFO_DEPTH words.
    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            accepted_now = 0;
            if (!reset && tx_valid && sb.size() < FIFO_DEPTH) begin
                sb.push_back('{data: tx_data, edge_no: cyc});
                accepted_now = 1;
                n_accepted++;
                $display("push  data=%02h edge=%0d", tx_data, cyc);
            end
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        forever begin
            @(negedge clock);
            if (active_flag && !active_prev) last_rise = cyc;
            active_prev = active_flag;
            if (done_flag) done_q.push_back(cyc);

            if (reset) begin
                sb.delete();
                mon_active = 0;
                prev_end   = cyc;
                done_cyc   = -1;
                check("reset_line", int'(data_tx), 1);
                check("reset_active", int'(active_flag), 0);
            end else begin
                if (mon_active) begin
                    pos = cyc - frame_start;
                    if (pos == frame_len) begin
                        mon_active = 0;
                        prev_end   = cyc;
                        done_cyc   = cyc;
                        $display("frame end   edge=%0d len=%0d", cyc, frame_len);
                    end else begin
                        check("line_bit", int'(data_tx), int'(exp_bits[pos / bit_time]));
                        check("active_in_frame", int'(active_flag), 1);
                    end
                end
                if (!mon_active) begin
                    start_at = prev_end;
                    if (sb.size() > 0 && sb[0].edge_no + 1 > start_at) start_at = sb[0].edge_no + 1;
                    if (sb.size() > 0 && cyc >= start_at) begin
                        ent = sb.pop_front();
                        bit_time = cfg_baud_prev + 1;
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < DATA_W; i++) exp_bits[1 + i] = ent.data[i];
                        n_bits = 1 + DATA_W;
                        if (cfg_par_prev == 2'b01) begin
                            exp_bits[n_bits] = ~^ent.data;
                            n_bits++;
                        end else if (cfg_par_prev == 2'b10) begin
                            exp_bits[n_bits] = ^ent.data;
                            n_bits++;
                        end
                        exp_bits[n_bits] = 1'b1;
                        n_bits++;
                        if (cfg_stop_prev) begin
                            exp_bits[n_bits] = 1'b1;
                            n_bits++;
                        end
                        frame_len   = n_bits * bit_time;
                        frame_start = cyc;
                        mon_active  = 1;
                        $display("frame start edge=%0d data=%02h div=%0d par=%0d stop2=%0d",
                                 cyc, ent.data, cfg_baud_prev, cfg_par_prev, cfg_stop_prev);
                        check("start_bit", int'(data_tx), 0);
                        check("active_start", int'(active_flag), 1);
                    end else begin
                        check("idle_line", int'(data_tx), 1);
                        check("idle_active", int'(active_flag), 0);
                    end
                end
            end
            check("done_flag", int'(done_flag), (cyc == done_cyc) ? 1 : 0);
            check("fifo_count", int'(fifo_count), sb.size());
            check("fifo_empty", int'(fifo_empty), (sb.size() == 0) ? 1 : 0);
            check("fifo_full", int'(fifo_full), (sb.size() == FIFO_DEPTH) ? 1 : 0);
            check("tx_ready", int'(tx_ready), (sb.size() < FIFO_DEPTH) ? 1 : 0);
            cfg_baud_prev = int'(baud_div);
            cfg_par_prev  = parity_type;
            cfg_stop_prev = stop_two;
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] d, input int max_cyc, output bit ok);
        tx_data  = d;
        tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(posedge clock);
            #1;
            ok = accepted_now;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle_ok = 0;
        for (int i = 0; i < max_cyc && !idle_ok; i++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0 && !mon_active && !active_flag) idle_ok = 1;
        end
        check("drain_in_time", int'(idle_ok), 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc0;
        int d0;

        reset       = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = '0;
        baud_div    = 16'd3;
        parity_type = 2'b00;
        stop_two    = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("reset_count", int'(fifo_count), 0);
        check("reset_ready", int'(tx_ready), 1);
        reset = 1'b0;

        // Odd parity, one stop, 4 clocks per bit: 44-clock frame.
        done_q.delete();
        baud_div = 16'd3; parity_type = 2'b01; stop_two = 1'b0;
        push_word(8'hAA, 10, ok);
        check("t1_accept", int'(ok), 1);
        wait_idle(500);
        check("t1_done_count", done_q.size(), 1);
        d0 = (done_q.size() > 0) ? done_q[0] : -1;
        check("t1_frame_len", d0 - last_rise, 44);

        // Even parity, two stops, 2 clocks per bit: 24-clock frame.
        done_q.delete();
        baud_div = 16'd1; parity_type = 2'b10; stop_two = 1'b1;
        push_word(8'h07, 10, ok);
        check("t2_accept", int'(ok), 1);
        wait_idle(500);
        check("t2_done_count", done_q.size(), 1);
        d0 = (done_q.size() > 0) ? done_q[0] : -1;
        check("t2_frame_len", d0 - last_rise, 24);

        // FIFO fill: 9 accepted, 10th refused while full; 9 gapless frames.
        done_q.delete();
        baud_div = 16'd15; parity_type = 2'b00; stop_two = 1'b0;
        acc0 = n_accepted;
        for (int i = 1; i <= 10; i++) begin
            push_word(8'(i), 30, ok);
            check("t3_accept", int'(ok), (i <= 9) ? 1 : 0);
        end
        check("t3_accepted_total", n_accepted - acc0, 9);
        check("t3_tx_ready_low", int'(tx_ready), 0);
        check("t3_fifo_full", int'(fifo_full), 1);
        wait_idle(3000);
        check("t3_done_count", done_q.size(), 9);
        d0 = (done_q.size() == 9) ? done_q[8] : -1;
        check("t3_train_len", d0 - last_rise, 9 * 160);

        // Reset in the middle of DATA bit 3 with 3 words queued.
        done_q.delete();
        baud_div = 16'd3; parity_type = 2'b00; stop_two = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'(8'h11 * (i + 1)), 10, ok);
            check("t4_accept", int'(ok), 1);
        end
        repeat (15) @(posedge clock);
        #1;
        check("t4_line_before", int'(active_flag), 1);
        reset = 1'b1;
        #1;
        check("t4_line_async", int'(data_tx), 1);
        check("t4_count_flush", int'(fifo_count), 0);
        check("t4_active_async", int'(active_flag), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("t4_no_done", done_q.size(), 0);
        check("t4_idle_line", int'(data_tx), 1);

        // Divisor change mid-frame applies only to the next frame.
        done_q.delete();
        baud_div = 16'd3; parity_type = 2'b00; stop_two = 1'b0;
        push_word(8'h5A, 10, ok);
        check("t5_accept1", int'(ok), 1);
        push_word(8'hC3, 10, ok);
        check("t5_accept2", int'(ok), 1);
        repeat (10) @(posedge clock);
        #1;
        baud_div = 16'd7;
        wait_idle(500);
        check("t5_done_count", done_q.size(), 2);
        d0 = (done_q.size() == 2) ? done_q[0] : -1;
        check("t5_frame1_len", d0 - last_rise, 40);
        d0 = (done_q.size() == 2) ? (done_q[1] - done_q[0]) : -1;
        check("t5_frame2_len", d0, 80);

        // Randomized traffic with random per-frame configuration, including
        // a divisor of zero (one clock per bit).
        baud_div = 16'd0; parity_type = 2'b01; stop_two = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                baud_div    = 16'($urandom_range(0, 3));
                parity_type = 2'($urandom_range(0, 3));
                stop_two    = 1'($urandom_range(0, 1));
            end
            push_word(8'($urandom), 1000, ok);
            check("rand_accept", int'(ok), 1);
            repeat ($urandom_range(0, 6)) @(posedge clock);
            #1;
        end
        wait_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, the successor to the fixed 8-bit, 2-bit-baud-select transmitter. Adds configurable data width, a runtime baud divisor, selectable parity and stop-bit count, and a ready/valid input FIFO so that frames are sent back-to-back without software pacing. It sits between the host-side byte source and the serial TX pin.

## Interface
- `DATA_W`, 8, data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 8, number of queued words; must be a power of two and at least 2.
- `DIV_W`, 16, width of the baud divisor.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  DATA_W  word to queue.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a word; equals `!fifo_full`.
- `baud_div`  in  DIV_W  clock cycles per bit, minus 1.
- `parity_type`  in  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
- `stop_two`  in  1  0 selects one stop bit; 1 selects two stop bits.
- `data_tx`  out  1  serial line; idles high.
- `active_flag`  out  1  high while a frame is on the line.
- `done_flag`  out  1  one-cycle pulse at the end of each frame.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of words currently queued.
- `fifo_empty`  out  1  FIFO holds no words.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH words.

## Operation
- Reset values: `data_tx`=1, `active_flag`=0, `done_flag`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `tx_ready`=1. The FSM enters IDLE.
- Push: a word is written on any edge where `tx_valid && tx_ready`.
- Pop: occurs in IDLE when the FIFO is non-empty, or at the end of the final STOP bit when the FIFO is non-empty.
- Simultaneous push and pop: `fifo_count` is unchanged. A push is never accepted while the FIFO is full, even if a pop occurs on the same edge.
- FSM states:
  - IDLE → START on a pop.
  - START → DATA after 1 bit time.
  - DATA sends DATA_W bits, LSB first.
  - DATA → PARITY if parity is enabled, otherwise → STOP.
  - PARITY → STOP after 1 bit time.
  - STOP lasts 1 or 2 bit times.
  - STOP → START if the FIFO is non-empty (pop), otherwise → IDLE.
- Bit time is `baud_div+1` clocks. The bit counter reloads at every bit boundary. `baud_div`=0 is legal and gives one clock per bit.
- Parity bit: odd mode = `~^data`; even mode = `^data`.
- Configuration latch: `baud_div`, `parity_type` and `stop_two` are sampled at the pop edge and held for the whole frame. Changes mid-frame take effect on the next frame.
- Line levels: `data_tx`=0 in START, the data bit in DATA, the parity bit in PARITY, 1 in STOP and IDLE. `data_tx` is driven from a register so the line is glitch-free.
- `active_flag`=1 in START, DATA, PARITY and STOP.
- Reset mid-frame: `data_tx` goes to 1 immediately (asynchronous), the FIFO is flushed, and no `done_flag` pulse is produced.

## Timing
- Accept-to-line latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1, and `data_tx` falls at edge k+1.
- Frame length: (1 + DATA_W + P + S)·(baud_div+1) clocks, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the stop-bit count.
- `done_flag` is high for the single cycle following the last STOP bit's final clock; it is registered on the same edge that leaves STOP.
- Back-to-back frames: the next START begins on the same edge as the `done_flag` pulse, with zero idle cycles.
- `tx_ready` and `fifo_count` are registered and update on the edge after the push or pop.

## Structure
- Shared package `uart_pkg` holds:
  - the parity encodings `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - a `frame_cfg_t` struct {`baud_div`, `parity_type`, `stop_two`}.
- Sub-module `uart_sync_fifo` (parameters DATA_W, FIFO_DEPTH): single clock, asynchronous active-high reset, with write/read pointers carrying an extra wrap bit.
- The top level holds the FSM, the baud counter, the bit index and the shift register.

## Test plan
- **Reset:** assert `reset` for 5 cycles → `data_tx`=1, `active_flag`=0, `tx_ready`=1, `fifo_count`=0, `done_flag` never pulses.
- **Odd parity, one stop:** DATA_W=8, `baud_div`=3, odd parity, one stop, push 0xAA → line carries 0, 0,1,0,1,0,1,0,1, parity 1, stop 1. Each level lasts 4 clocks, the frame is 44 clocks, and `done_flag` pulses once at clock 44.
- **Even parity, two stops:** even parity, `stop_two`=1, `baud_div`=1, push 0x07 → bits 0, 1,1,1,0,0,0,0,0, parity 1, stop 1,1. Frame is 24 clocks.
- **FIFO fill:** `baud_div`=15, hold `tx_valid` high with 0x01..0x0A → 9 words accepted (1 popped, 8 queued), then `tx_ready`=0 and `fifo_full`=1. Expect 9 consecutive frames with no idle gap and 9 `done_flag` pulses.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 3 words queued → `data_tx`=1 immediately, `fifo_count`=0, no `done_flag`, and the FSM is in IDLE after release.
- **Config change mid-frame:** no parity; change `baud_div` from 3 to 7 during frame 1 → frame 1 stays 40 clocks and frame 2 is 80 clocks.
